// File: rtl/mem_pkg.sv
// Shared types and access-legality helper for the load/store sequencer.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        DONE
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Misaligned address or unsupported funct3 for the given direction.
    function automatic logic access_err(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] lane);
        logic bad;
        bad = 1'b1;
        if (is_store) begin
            case (funct3)
                F3_SB:   bad = 1'b0;
                F3_SH:   bad = lane[0];
                F3_SW:   bad = (lane != 2'b00);
                default: bad = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: bad = 1'b0;
                F3_LH, F3_LHU: bad = lane[0];
                F3_LW:         bad = (lane != 2'b00);
                default:       bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/half lane steering: load extract with sign/zero extension and store merge.
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] r_data,
    input  logic [31:0] w_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = r_data[{lane, 3'b000} +: 8];
        half_sel = r_data[{lane[1], 4'b0000} +: 16];

        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data = {24'h000000, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data = {16'h0000, half_sel};
            F3_LW:   load_data = r_data;
            default: load_data = '0;
        endcase

        merge_data = r_data;
        case (funct3)
            F3_SB:   merge_data[{lane, 3'b000} +: 8]     = w_data[7:0];
            F3_SH:   merge_data[{lane[1], 4'b0000} +: 16] = w_data[15:0];
            default: merge_data = w_data;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: issues word reads/writes to the mmu, RMW for SB/SH, stalls the pipe.
module lsu_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_w_data,
    output logic                  stall,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  mem_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    input  logic                  mem_ready
);

    lsu_state_t            state;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [1:0]            lane_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [31:0]           wait_cnt;
    logic [31:0]           ext_data;
    logic [31:0]           merge_data;
    logic                  timed_out;

    lsu_align u_align (
        .funct3     (f3_q),
        .lane       (lane_q),
        .r_data     (mem_r_data),
        .w_data     (wdata_q),
        .load_data  (ext_data),
        .merge_data (merge_data)
    );

    assign stall     = ((state != IDLE) && (state != DONE)) || ((state == IDLE) && req_valid);
    assign timed_out = (TIMEOUT != 0) && (wait_cnt == TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= '0;
            lane_q     <= '0;
            wdata_q    <= '0;
            wait_cnt   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            load_data  <= '0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_w_data <= '0;
        end else begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        f3_q       <= req_funct3;
                        lane_q     <= req_addr[1:0];
                        wdata_q    <= req_w_data;
                        mem_addr   <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_w_data <= req_w_data;
                        if (access_err(req_we, req_funct3, req_addr[1:0])) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                            load_data <= '0;
                        end else if (!req_we || (req_funct3 != F3_SW)) begin
                            state     <= RD_ISSUE;
                            mem_valid <= 1'b1;
                        end else begin
                            state     <= WR_ISSUE;
                            mem_valid <= 1'b1;
                            mem_we    <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: begin
                    state    <= RD_WAIT;
                    wait_cnt <= '0;
                end
                RD_WAIT: begin
                    if (mem_ready) begin
                        if (!we_q) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            load_data <= ext_data;
                        end else begin
                            // Sub-word store: fold the new lane into the word just read back.
                            mem_w_data <= merge_data;
                            state      <= WR_ISSUE;
                            mem_valid  <= 1'b1;
                            mem_we     <= 1'b1;
                        end
                    end else if (timed_out) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        load_data <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                WR_ISSUE: begin
                    state    <= WR_WAIT;
                    wait_cnt <= '0;
                end
                WR_WAIT: begin
                    if (mem_ready) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        load_data <= '0;
                    end else if (timed_out) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        load_data <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl: timeline model per request plus reactive mmu model.
module tb_lsu_ctrl;

    localparam int unsigned TO = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_w_data;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;
    logic        mem_ready;

    lsu_ctrl #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_w_data (req_w_data),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .load_data  (load_data),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mmu model state
    logic [31:0] mem [16];
    int          plan[$];
    bit          stray = 1'b0;
    bit          pend = 1'b0;
    int          left = 0;
    logic [31:0] rdp = '0;

    // expected timeline of the current request
    bit          chk_en = 1'b0;
    int          s_cyc = -100;
    int          done_cyc = -100;
    int          n_tx = 0;
    int          v_cyc[2];
    int          e_cyc[2];
    bit          tx_we[2];
    logic [31:0] tx_wdata[2];
    logic [31:0] tx_addr;
    bit          exp_err = 1'b0;
    logic [31:0] next_load = '0;
    bit          next_known = 1'b0;
    logic [31:0] cur_load = '0;
    bit          cur_known = 1'b0;

    // observations for literal pins
    int          obs_lat;
    int          obs_nvalid;
    logic [31:0] obs_load;
    logic        obs_err;
    logic [31:0] obs_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reactive mmu: one outstanding access, write committed at mem_valid.
    initial begin
        mem_ready  = 1'b0;
        mem_r_data = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (rst) begin
                pend = 1'b0;
                plan.delete();
            end else begin
                if (stray) begin
                    mem_ready  = 1'b1;
                    mem_r_data = $urandom;
                    stray      = 1'b0;
                end
                if (pend) begin
                    left--;
                    if (left == 0) begin
                        mem_ready  = 1'b1;
                        mem_r_data = rdp;
                        pend       = 1'b0;
                    end
                end
                if (mem_valid) begin
                    int l;
                    l = (plan.size() != 0) ? plan.pop_front() : 0;
                    if (mem_we) mem[mem_addr[5:2]] = mem_w_data;
                    rdp = mem[mem_addr[5:2]];
                    if (l > 0) begin
                        left = l;
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the expected timeline.
    always @(negedge clk) begin
        bit ed;
        bit ev;
        bit ew;
        if (chk_en) begin
            ed = (cyc == done_cyc);
            if (ed) begin
                cur_load  = next_load;
                cur_known = next_known;
            end
            chk("stall", stall, req_valid && !ed);
            chk("done", done, ed);
            chk("err", err, ed && exp_err);
            if (cur_known) chk("load_data", load_data, cur_load);
            ev = 1'b0;
            ew = 1'b0;
            for (int i = 0; i < n_tx; i++) begin
                if (cyc == v_cyc[i]) begin
                    ev = 1'b1;
                    ew = tx_we[i];
                end
                if (cyc >= v_cyc[i] && cyc <= e_cyc[i]) begin
                    chk("mem_addr", mem_addr, tx_addr);
                    if (tx_we[i]) chk("mem_w_data", mem_w_data, tx_wdata[i]);
                end
            end
            chk("mem_valid", mem_valid, ev);
            chk("mem_we", mem_we, ew);
            if (done) begin
                obs_lat  = cyc - s_cyc;
                obs_load = load_data;
                obs_err  = err;
            end
            if (mem_valid) obs_nvalid++;
            if (mem_valid && mem_we) obs_wdata = mem_w_data;
        end
    end

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] w, input logic [31:0] d);
        if (f3 == 3'd0)
            return (w & ~(32'hFF << (8 * a[1:0]))) | ((d & 32'hFF) << (8 * a[1:0]));
        return (w & ~(32'hFFFF << (16 * a[1]))) | ((d & 32'hFFFF) << (16 * a[1]));
    endfunction

    function automatic bit is_bad(input bit we, input logic [2:0] f3, input logic [31:0] a);
        if (we) begin
            if (f3 == 3'd0) return 1'b0;
            if (f3 == 3'd1) return a[0];
            if (f3 == 3'd2) return a[1:0] != 2'b00;
            return 1'b1;
        end
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return a[0];
        if (f3 == 3'd2) return a[1:0] != 2'b00;
        return 1'b1;
    endfunction

    // Called at #2 of the start cycle; returns at #2 of the cycle after done.
    task automatic run_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int l1, input int l2);
        logic [31:0] word;
        bit          to1;
        bit          to2;
        word       = mem[a[5:2]];
        s_cyc      = cyc;
        obs_lat    = -1;
        obs_nvalid = 0;
        tx_addr    = {a[31:2], 2'b00};
        if (is_bad(we, f3, a)) begin
            n_tx       = 0;
            done_cyc   = s_cyc + 1;
            exp_err    = 1'b1;
            next_load  = '0;
            next_known = 1'b1;
        end else begin
            to1         = (l1 == 0) || (l1 > TO);
            n_tx        = 1;
            v_cyc[0]    = s_cyc + 1;
            e_cyc[0]    = v_cyc[0] + (to1 ? TO : l1);
            tx_we[0]    = we && (f3 == 3'd2);
            tx_wdata[0] = d;
            plan.push_back(l1);
            done_cyc    = e_cyc[0] + 1;
            exp_err     = to1;
            next_load   = '0;
            next_known  = to1 || !we;
            if (!to1 && !we) next_load = extract(f3, a, word);
            if (!to1 && we && f3 != 3'd2) begin
                to2         = (l2 == 0) || (l2 > TO);
                n_tx        = 2;
                v_cyc[1]    = e_cyc[0] + 1;
                e_cyc[1]    = v_cyc[1] + (to2 ? TO : l2);
                tx_we[1]    = 1'b1;
                tx_wdata[1] = merge(f3, a, word, d);
                plan.push_back(l2);
                done_cyc    = e_cyc[1] + 1;
                exp_err     = to2;
                next_known  = to2;
            end
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_w_data = d;
        while (cyc <= done_cyc) step();
        req_valid = 1'b0;
    endtask

    function automatic int draw_lat();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 4) return 1;
        if (r <= 6) return $urandom_range(2, 5);
        if (r == 7) return TO;
        if (r == 8) return $urandom_range(TO + 1, TO + 2);
        return 0;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, stall, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_load_data"}, load_data, 32'h0);
        chk({tag, "_mem_valid"}, mem_valid, 1'b0);
        chk({tag, "_mem_we"}, mem_we, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_w_data"}, mem_w_data, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_w_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #3;
        check_all_zero("reset");
        cur_load  = '0;
        cur_known = 1'b1;
        chk_en    = 1'b1;
        step();

        // LW hit
        mem[0] = 32'hDEAD_BEEF;
        run_req(1'b0, 3'd2, 32'h100, 32'h0, 1, 0);
        chk("t1_lat", obs_lat, 32'd3);
        chk("t1_load", obs_load, 32'hDEAD_BEEF);
        chk("t1_err", obs_err, 1'b0);
        chk("t1_nvalid", obs_nvalid, 32'd1);

        // LB / LBU on upper byte
        mem[0] = 32'h80FF_0000;
        run_req(1'b0, 3'd0, 32'h103, 32'h0, 1, 0);
        chk("t2_lb", obs_load, 32'hFFFF_FF80);
        run_req(1'b0, 3'd4, 32'h103, 32'h0, 1, 0);
        chk("t2_lbu", obs_load, 32'h0000_0080);

        // SB read-modify-write
        mem[0] = 32'h1122_3344;
        run_req(1'b1, 3'd0, 32'h102, 32'h0000_00AB, 1, 1);
        chk("t3_wdata", obs_wdata, 32'h11AB_3344);
        chk("t3_lat", obs_lat, 32'd5);
        chk("t3_nvalid", obs_nvalid, 32'd2);
        chk("t3_mem", mem[0], 32'h11AB_3344);

        // misaligned
        run_req(1'b0, 3'd1, 32'h101, 32'h0, 1, 0);
        chk("t4_lh_lat", obs_lat, 32'd1);
        chk("t4_lh_err", obs_err, 1'b1);
        chk("t4_lh_nvalid", obs_nvalid, 32'd0);
        run_req(1'b1, 3'd2, 32'h102, 32'h1234_5678, 1, 0);
        chk("t4_sw_lat", obs_lat, 32'd1);
        chk("t4_sw_err", obs_err, 1'b1);
        chk("t4_sw_nvalid", obs_nvalid, 32'd0);
        step();

        // miss, ready exactly at the timeout boundary, and no ready at all
        mem[0] = 32'hCAFE_F00D;
        run_req(1'b0, 3'd2, 32'h100, 32'h0, 5, 0);
        chk("t5_miss_lat", obs_lat, 32'd7);
        chk("t5_miss_nvalid", obs_nvalid, 32'd1);
        chk("t5_miss_load", obs_load, 32'hCAFE_F00D);
        run_req(1'b0, 3'd2, 32'h100, 32'h0, TO, 0);
        chk("t5_edge_lat", obs_lat, 32'd8);
        chk("t5_edge_err", obs_err, 1'b0);
        run_req(1'b0, 3'd2, 32'h100, 32'h0, 0, 0);
        chk("t5_to_lat", obs_lat, 32'd8);
        chk("t5_to_err", obs_err, 1'b1);
        chk("t5_to_load", obs_load, 32'h0);

        // reset while waiting for read data
        s_cyc      = cyc;
        n_tx       = 1;
        v_cyc[0]   = cyc + 1;
        e_cyc[0]   = cyc + 2;
        tx_we[0]   = 1'b0;
        tx_addr    = 32'h104;
        done_cyc   = -100;
        plan.push_back(0);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h104;
        step();
        step();
        chk_en    = 1'b0;
        rst       = 1'b1;
        req_valid = 1'b0;
        step();
        rst = 1'b0;
        #3;
        check_all_zero("rst_mid");
        n_tx      = 0;
        cur_load  = '0;
        cur_known = 1'b1;
        chk_en    = 1'b1;
        stray     = 1'b1;
        step();
        step();
        step();
        mem[1] = 32'h0BAD_F00D;
        run_req(1'b0, 3'd2, 32'h104, 32'h0, 1, 0);
        chk("t6_lat", obs_lat, 32'd3);
        chk("t6_load", obs_load, 32'h0BAD_F00D);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            bit          we;
            logic [2:0]  f3;
            logic [31:0] a;
            int          gap;
            we = $urandom_range(0, 1);
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a[0] = 1'b0;
            if ($urandom_range(0, 2) != 0) a[1] = 1'b0;
            run_req(we, f3, a, $urandom, draw_lat(), draw_lat());
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                req_we     = $urandom;
                req_funct3 = $urandom;
                req_addr   = $urandom;
                req_w_data = $urandom;
                if ($urandom_range(0, 3) == 0) stray = 1'b1;
                step();
            end
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
